// File: rtl/sram_burst_ctrl.sv
// Burst initiator for one single-port SRAM: one command at a time. Write beats go
// straight to the SRAM pins, and read beats land in a one-deep output register.
module sram_burst_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 30,
    parameter int RAM_DEPTH  = 64,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_mem_cs,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    input  logic [DATA_WIDTH-1:0] i_mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD       = 2'd2,
        ST_RD_DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    // Depth need not be a power of two, so wrap explicitly at the last word
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] nxt;
        if (addr == LAST_ADDR) begin
            nxt = '0;
        end else begin
            nxt = addr + ADDR_WIDTH'(1'b1);
        end
        return nxt;
    endfunction

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] cur_addr_r, cur_addr_s;
    logic [LEN_WIDTH-1:0]  remaining_r, remaining_s;
    logic                  rd_valid_r, rd_valid_s;
    logic [DATA_WIDTH-1:0] rd_data_r, rd_data_s;
    logic                  done_r, done_s;
    logic                  err_r, err_s;
    logic                  cmd_ready_s;
    logic                  wr_ready_s;
    logic                  mem_cs_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_din_s;
    logic                  cmd_bad_s;

    assign cmd_bad_s = ({1'b0, i_cmd_addr} >= DEPTH_EXT);

    // Next-state, per-beat datapath update and SRAM pin decode
    always_comb begin
        state_s     = state_r;
        cur_addr_s  = cur_addr_r;
        remaining_s = remaining_r;
        rd_data_s   = rd_data_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        cmd_ready_s = 1'b0;
        wr_ready_s  = 1'b0;
        mem_cs_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_din_s   = '0;
        if (rd_valid_r && i_rd_ready) begin
            rd_valid_s = 1'b0;
        end else begin
            rd_valid_s = rd_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                if (i_cmd_valid && cmd_bad_s) begin
                    done_s = 1'b1;
                    err_s  = 1'b1;
                end else if (i_cmd_valid) begin
                    cur_addr_s  = i_cmd_addr;
                    remaining_s = i_cmd_len;
                    state_s     = i_cmd_we ? ST_WR : ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR: begin
                wr_ready_s = 1'b1;
                mem_we_s   = 1'b1;
                mem_cs_s   = i_wr_valid;
                mem_addr_s = cur_addr_r;
                mem_din_s  = i_wr_data;
                if (i_wr_valid) begin
                    cur_addr_s  = next_addr(cur_addr_r);
                    remaining_s = remaining_r - LEN_WIDTH'(1'b1);
                    if (remaining_r == '0) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_WR;
                    end
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_RD: begin
                // Issue only when the output register is empty or emptying this cycle
                mem_cs_s   = !rd_valid_r || i_rd_ready;
                mem_addr_s = cur_addr_r;
                if (mem_cs_s) begin
                    rd_valid_s  = 1'b1;
                    rd_data_s   = i_mem_dout;
                    cur_addr_s  = next_addr(cur_addr_r);
                    remaining_s = remaining_r - LEN_WIDTH'(1'b1);
                    if (remaining_r == '0) begin
                        state_s = ST_RD_DRAIN;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_RD_DRAIN: begin
                if (rd_valid_r && i_rd_ready) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_RD_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            cur_addr_r  <= '0;
            remaining_r <= '0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cur_addr_r  <= cur_addr_s;
            remaining_r <= remaining_s;
            rd_valid_r  <= rd_valid_s;
            rd_data_r   <= rd_data_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    // The SRAM must see no strobe while reset is held, whatever state was left behind
    assign o_mem_cs    = i_rst ? 1'b0 : mem_cs_s;
    assign o_mem_we    = i_rst ? 1'b0 : mem_we_s;
    assign o_wr_ready  = i_rst ? 1'b0 : wr_ready_s;
    assign o_mem_addr  = mem_addr_s;
    assign o_mem_din   = mem_din_s;
    assign o_cmd_ready = cmd_ready_s;
    assign o_rd_valid  = rd_valid_r;
    assign o_rd_data   = rd_data_r;
    assign o_done      = done_r;
    assign o_err       = err_r;

endmodule
